// File: rtl/seg7_scan_ctrl.sv
// 4-digit multiplexed 7-segment controller: sequential double-dabble BCD conversion,
// sign/blanking/overflow formatting, and a free-running digit scanner.
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        neg,
  input  logic        load,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  bcd_out,
  output logic [3:0]  an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [13:0] shreg, val_q;
  logic [15:0] bcd, bcd_adj;
  logic        neg_q;
  logic [3:0]  iter;
  logic [3:0]  disp [4];
  logic [3:0]  disp_nxt [4];
  logic        ovf_q, ovf_nxt;
  logic [1:0]  msd;
  logic [CW-1:0] rcnt;
  logic [1:0]  idx;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONV;
      CONV:    if (iter == 4'd13) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = (state != IDLE);
    overflow = ovf_q;
    an       = ~(4'b0001 << idx);
    bcd_out  = disp[idx];
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      bcd_adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
  end

  // Commit formatting; the raw magnitude is kept because values above 9999 overrun the BCD accumulator.
  always_comb begin
    ovf_nxt = (val_q > 14'd9999) || (neg_q && (val_q > 14'd999));
    msd     = 2'd0;
    for (int i = 1; i < 4; i++)
      if (bcd[i*4 +: 4] != 4'd0) msd = 2'(i);
    for (int i = 0; i < 4; i++) begin
      if (ovf_nxt)
        disp_nxt[i] = CODE_DASH;
      else if (i <= int'(msd))
        disp_nxt[i] = bcd[i*4 +: 4];
      else if (neg_q && (val_q != 14'd0) && (i == int'(msd) + 1))
        disp_nxt[i] = CODE_DASH;
      else
        disp_nxt[i] = CODE_BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      val_q <= '0;
      neg_q <= 1'b0;
      bcd   <= '0;
      iter  <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < 4; i++) disp[i] <= CODE_BLANK;
    end else begin
      case (state)
        IDLE: if (load) begin
          shreg <= value;
          val_q <= value;
          neg_q <= neg;
          bcd   <= '0;
          iter  <= '0;
        end
        CONV: begin
          {bcd, shreg} <= {bcd_adj[14:0], shreg, 1'b0};
          iter         <= iter + 4'd1;
        end
        COMMIT: begin
          ovf_q <= ovf_nxt;
          for (int i = 0; i < 4; i++) disp[i] <= disp_nxt[i];
        end
        default: ;
      endcase
    end
  end

  // Scanner runs independently of conversion so the display never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt <= '0;
      idx  <= 2'd0;
    end else if (rcnt == CW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: expected displays are queued at load and compared over a scan frame.
module tb_seg7_scan_ctrl;

  localparam int DIV = 4;

  typedef struct packed {
    logic        ovf;
    logic [15:0] digs;  // d3..d0
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] value = '0;
  logic        neg = 1'b0;
  logic        load = 1'b0;
  logic        busy, overflow;
  logic [3:0]  bcd_out, an;

  int   errors = 0;
  int   checks = 0;
  int   cyc;
  exp_t sb[$];

  seg7_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .value(value), .neg(neg), .load(load),
    .busy(busy), .overflow(overflow), .bcd_out(bcd_out), .an(an)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; the scan slot is cyc/DIV mod 4.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int v, input bit n);
    exp_t r;
    int d[4];
    int m = 0;
    int p = 1;
    for (int i = 0; i < 4; i++) begin
      d[i] = (v / p) % 10;
      p = p * 10;
    end
    for (int i = 0; i < 4; i++)
      if (d[i] != 0) m = i;
    r.ovf = (v > 9999) || (n && v > 999);
    for (int i = 0; i < 4; i++) begin
      if (r.ovf)                           r.digs[i*4 +: 4] = 4'd10;
      else if (i <= m)                     r.digs[i*4 +: 4] = 4'(d[i]);
      else if (n && v != 0 && i == m + 1)  r.digs[i*4 +: 4] = 4'd10;
      else                                 r.digs[i*4 +: 4] = 4'd11;
    end
    return r;
  endfunction

  task automatic check_frame(input exp_t e);
    logic [3:0] exp_an;
    int         slot;
    chk("overflow", 16'(overflow), 16'(e.ovf));
    for (int i = 0; i < 4 * DIV; i++) begin
      slot   = (cyc / DIV) % 4;
      exp_an = ~(4'b0001 << slot);
      chk("an", 16'(an), 16'(exp_an));
      chk("bcd_out", 16'(bcd_out), 16'(e.digs[slot*4 +: 4]));
      tick();
    end
  endtask

  // Load v/n; optionally pulse a second load (value 1111) at cycle drop_at while busy.
  task automatic do_load(input int v, input bit n, input int drop_at);
    int k = 0;
    value = 14'(v);
    neg   = n;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    sb.push_back(model(v, n));
    while (busy === 1'b1 && k < 40) begin
      if (drop_at != 0 && k == drop_at - 1) begin
        value = 14'd1111;
        neg   = 1'b0;
        load  = 1'b1;
      end
      tick();
      load = 1'b0;
      k++;
    end
    chk("busy_cycles", 16'(k), 16'd15);
    check_frame(sb.pop_front());
    chk("busy_idle", 16'(busy), 16'd0);
  endtask

  initial begin
    exp_t blank;
    blank.ovf  = 1'b0;
    blank.digs = 16'hBBBB;

    repeat (3) tick();
    chk("rst_an", 16'(an), 16'hE);
    chk("rst_bcd", 16'(bcd_out), 16'd11);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    rst = 1'b0;
    sb.push_back(blank);
    check_frame(sb.pop_front());

    do_load(1234, 1'b0, 0);
    do_load(42, 1'b1, 0);
    do_load(0, 1'b0, 0);
    do_load(0, 1'b1, 0);
    do_load(10000, 1'b0, 0);
    do_load(1000, 1'b1, 0);
    do_load(999, 1'b1, 0);
    do_load(5678, 1'b0, 5);
    do_load(16383, 1'b0, 0);
    do_load(7, 1'b1, 0);

    // Abort mid-conversion: nothing partial may be committed.
    value = 14'd9999;
    neg   = 1'b0;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("abort_an", 16'(an), 16'hE);
    chk("abort_bcd", 16'(bcd_out), 16'd11);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_ovf", 16'(overflow), 16'd0);
    tick();
    tick();
    rst = 1'b0;
    sb.push_back(blank);
    check_frame(sb.pop_front());
    chk("abort_busy_after", 16'(busy), 16'd0);

    do_load(8051, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
